down_counter_timer: RTL and testbench

Synchronous programmable down-counter/timer with a 4-bit default width. It loads a reload value, counts down to zero on enabled clock edges, and flags terminal count. It runs in one-shot or auto-reload mode and has a start/stop/done control handshake. It complements the existing ripple up-counter: where that block counts upward, this one counts down from a loaded value for timeout and period generation. All flops are clocked on the rising edge and no derived clocks are used.

---
 rtl/down_counter_timer.sv | 83 ++++++++
 tb/tb_down_counter_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// down_counter_timer: programmable down-counter/timer with a reload register.
// Supports one-shot and auto-reload modes with a start/stop/done handshake.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_eff;

  // reload value as seen this edge, including a same-cycle load
  assign rld_eff = load ? load_val : rld;

  // state, counter, reload register and terminal-count pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= ZERO;
      rld   <= ZERO;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) rld <= load_val;
      if (stop) begin
        state <= IDLE;
        if (load) count <= load_val;
      end else if (start) begin
        state <= RUN;
        count <= rld_eff;
      end else begin
        unique case (state)
          IDLE: begin
            if (load) count <= load_val;
          end
          RUN: begin
            if (en) begin
              if (count != ZERO) begin
                count <= count - ONE;
              end else begin
                tc <= 1'b1;
                if (mode) count <= rld_eff;
                else      state <= DONE;
              end
            end
          end
          DONE: begin
            count <= ZERO;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // status flags decoded from registered state
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed scoreboard bench for down_counter_timer.
// Stimulus pushes expected outputs; a monitor pops and compares after each edge.
module tb_down_counter_timer;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  exp_t q[$];
  int   n_chk;
  int   n_pass;
  bit   fin;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = '{count: count, tc: tc, busy: busy, done: done};
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                  nm, a.count, a.tc, a.busy, a.done,
                  e.count, e.tc, e.busy, e.done);
  endtask

  // monitor: one expected entry per clock edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) check("edge", q.pop_front());
    end
  end

  task automatic step(input logic e, input logic ld, input logic [3:0] lv,
                      input logic st, input logic sp, input logic md,
                      input logic [3:0] c, input logic t,
                      input logic b, input logic d);
    exp_t x;
    @(negedge clk);
    en = e; load = ld; load_val = lv;
    start = st; stop = sp; mode = md;
    x = '{count: c, tc: t, busy: b, done: d};
    q.push_back(x);
  endtask

  initial begin
    int waitc;
    logic [3:0] pat [3];
    n_chk = 0; n_pass = 0; fin = 0;
    rst = 1'b0; en = 0; load = 0; load_val = 0;
    start = 0; stop = 0; mode = 0;
    pat[0] = 4'd1; pat[1] = 4'd0; pat[2] = 4'd2;
    #23;
    check("reset", '{count: 4'd0, tc: 1'b0, busy: 1'b0, done: 1'b0});
    @(negedge clk); rst = 1'b1;

    // reset mid-run
    step(0, 1, 4'd9, 1, 0, 0, 4'd9, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd8, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd7, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd6, 0, 1, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_rst", '{count: 4'd0, tc: 1'b0, busy: 1'b0, done: 1'b0});
    @(negedge clk); rst = 1'b1;
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

    // load in idle
    step(0, 1, 4'd5, 0, 0, 0, 4'd5, 0, 0, 0);

    // one-shot
    step(1, 1, 4'd3, 1, 0, 0, 4'd3, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);

    // auto-reload, period 3
    step(1, 1, 4'd2, 1, 0, 1, 4'd2, 0, 1, 0);
    for (int i = 1; i <= 12; i++)
      step(1, 0, 4'd0, 0, 0, 1, pat[(i-1)%3], (i%3 == 0), 1, 0);

    // enable gating
    step(0, 0, 4'd0, 0, 1, 0, 4'd2, 0, 0, 0);
    step(0, 1, 4'd3, 1, 0, 0, 4'd3, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
    step(0, 0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
    step(0, 0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
    step(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
    step(0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);

    // stop / restart
    step(0, 1, 4'd7, 1, 0, 0, 4'd7, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd6, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd5, 0, 1, 0);
    step(1, 0, 4'd0, 0, 1, 0, 4'd5, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd5, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd7, 0, 1, 0);
    step(0, 1, 4'd10, 1, 0, 0, 4'd10, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd9, 0, 1, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd10, 0, 1, 0);

    // zero reload
    step(1, 1, 4'd0, 1, 0, 1, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 0, 0, 1, 4'd0, 1, 1, 0);
    step(1, 0, 4'd0, 0, 0, 1, 4'd0, 1, 1, 0);
    step(1, 0, 4'd0, 0, 0, 1, 4'd0, 1, 1, 0);
    step(1, 0, 4'd0, 0, 1, 1, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);

    @(negedge clk);
    en = 0; load = 0; start = 0; stop = 0;
    waitc = 0;
    while (q.size() > 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    fin = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    if (!fin) begin
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1);
    end
  end

endmodule
